// File: rtl/uart_word_tx_pkg.sv
// Shared types and constants for the word-oriented UART transmitter.
package uart_word_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_mode_t;

    localparam int unsigned START_BITS = 1;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned MIN_DIV    = 2;

    function automatic logic parity_bit(input logic [7:0] data, input parity_mode_t mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Power-of-two word FIFO with wrap-bit pointers; simultaneous push and pop both take effect.
module uart_tx_fifo
    import uart_word_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty_o = (r_wptr == r_rptr);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign rdata_o = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: empty pointers hide stale contents.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_word_tx.sv
// Serialises buffered words as LSB-first UART bytes with optional parity and 1/2 stop bits.
// States: IDLE = line idle / fetching a word | START = start bit | DATA = 8 data bits
//         PARITY = parity bit | STOP = one or two stop bits
module uart_word_tx
    import uart_word_tx_pkg::*;
#(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic              cfg_parity_en_i,
    input  logic              cfg_parity_odd_i,
    input  logic              cfg_stop2_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    input  logic [WORD_W-1:0] word_i,
    output logic              uart_tx_o,
    output logic              busy_o,
    output logic [31:0]       bytes_sent_o
);
    localparam int unsigned NBYTES = WORD_W / 8;
    localparam int unsigned BC_W   = $clog2(NBYTES + 1);

    tx_state_t         r_state;
    logic              r_ready_en;
    logic [DIV_W-1:0]  r_cnt;
    logic [DIV_W-1:0]  r_div_m1;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit_idx;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_stop2;
    logic              r_stop_left;
    logic [WORD_W-1:0] r_word;
    logic [BC_W-1:0]   r_bytes_left;
    logic              r_tx;
    logic [31:0]       r_bytes_sent;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [WORD_W-1:0] w_fifo_rdata;
    logic              w_push;
    logic              w_pop;
    logic              w_bit_end;
    logic              w_stop_end;
    logic              w_have_bytes;
    logic              w_enter_start;
    logic [WORD_W-1:0] w_src_word;
    logic [DIV_W-1:0]  w_div_m1;

    assign word_ready_o = r_ready_en && !w_fifo_full;
    assign w_push       = word_valid_i && word_ready_o;

    uart_tx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .wdata_i (word_i),
        .pop_i   (w_pop),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    assign w_div_m1 = (cfg_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV - 1)
                                                    : cfg_div_i - DIV_W'(1);

    assign w_bit_end    = (r_cnt == '0);
    assign w_stop_end   = (r_state == ST_STOP) && w_bit_end && !r_stop_left;
    assign w_have_bytes = (r_bytes_left != '0);
    assign w_src_word   = w_have_bytes ? r_word : w_fifo_rdata;

    // A word is fetched in IDLE one cycle ahead of its start bit; at the end of a
    // frame the next byte (from the held word or straight from the FIFO) starts at once.
    assign w_enter_start = ((r_state == ST_IDLE) && w_have_bytes)
                        || (w_stop_end && (w_have_bytes || !w_fifo_empty));
    assign w_pop = !w_fifo_empty && !w_have_bytes
                && ((r_state == ST_IDLE) || w_stop_end);

    assign busy_o       = !w_fifo_empty || (r_state != ST_IDLE) || w_have_bytes;
    assign uart_tx_o    = r_tx;
    assign bytes_sent_o = r_bytes_sent;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_ready_en   <= 1'b0;
            r_cnt        <= '0;
            r_div_m1     <= '0;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_par_en     <= 1'b0;
            r_par_bit    <= 1'b0;
            r_stop2      <= 1'b0;
            r_stop_left  <= 1'b0;
            r_word       <= '0;
            r_bytes_left <= '0;
            r_tx         <= 1'b1;
            r_bytes_sent <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (!w_bit_end) r_cnt <= r_cnt - DIV_W'(1);

            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state   <= ST_DATA;
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                        r_cnt     <= r_div_m1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= r_div_m1;
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                            if (r_par_en) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state     <= ST_STOP;
                                r_tx        <= 1'b1;
                                r_stop_left <= r_stop2;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state     <= ST_STOP;
                        r_tx        <= 1'b1;
                        r_stop_left <= r_stop2;
                        r_cnt       <= r_div_m1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_left) begin
                            r_stop_left <= 1'b0;
                            r_cnt       <= r_div_m1;
                        end else begin
                            r_bytes_sent <= r_bytes_sent + 32'd1;
                            r_state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase

            // Frame configuration is latched here and held for the whole frame.
            if (w_enter_start) begin
                r_state   <= ST_START;
                r_tx      <= 1'b0;
                r_cnt     <= w_div_m1;
                r_div_m1  <= w_div_m1;
                r_shift   <= w_src_word[7:0];
                r_par_en  <= cfg_parity_en_i;
                r_par_bit <= parity_bit(w_src_word[7:0], parity_mode_t'(cfg_parity_odd_i));
                r_stop2   <= cfg_stop2_i;
            end

            if (w_pop) begin
                if (w_enter_start) begin
                    r_word       <= w_fifo_rdata >> 8;
                    r_bytes_left <= BC_W'(NBYTES - 1);
                end else begin
                    r_word       <= w_fifo_rdata;
                    r_bytes_left <= BC_W'(NBYTES);
                end
            end else if (w_enter_start) begin
                r_word       <= r_word >> 8;
                r_bytes_left <= r_bytes_left - BC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: framing, parity, stop bits, FIFO back-pressure, reset abort.
module tb_uart_word_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] cfg_div = 16'd10;
    logic        par_en = 1'b0;
    logic        par_odd = 1'b0;
    logic        stop2 = 1'b0;
    logic        wvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic        wready;
    logic        tx;
    logic        busy;
    logic [31:0] bsent;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    int          rs [24];
    logic [7:0]  rb [24];
    logic        rp [24];
    int          n_acc;
    logic [31:0] words [6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_word_tx #(
        .WORD_W     (32),
        .FIFO_DEPTH (4),
        .DIV_W      (16)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cfg_div_i        (cfg_div),
        .cfg_parity_en_i  (par_en),
        .cfg_parity_odd_i (par_odd),
        .cfg_stop2_i      (stop2),
        .word_valid_i     (wvalid),
        .word_ready_o     (wready),
        .word_i           (wdata),
        .uart_tx_o        (tx),
        .busy_o           (busy),
        .bytes_sent_o     (bsent)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_start(output int s);
        int t;
        t = 0;
        @(negedge clk);
        while (tx !== 1'b0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) chk("start_timeout", t, 0);
        s = cyc;
    endtask

    task automatic push(input logic [31:0] w, output int acc);
        int t;
        t = 0;
        @(negedge clk);
        wvalid = 1'b1;
        wdata  = w;
        while (wready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("push_timeout", t, 0);
        @(posedge clk);
        #1;
        acc    = cyc;
        wvalid = 1'b0;
    endtask

    task automatic rx(input int div, input bit pe, input bit s2, input int k);
        int d;
        int s;
        int idx;
        logic [7:0] b;
        d = (div < 2) ? 2 : div;
        wait_start(s);
        for (int i = 0; i < 8; i++) begin
            wait_until(s + (1 + i) * d + d / 2);
            b[i] = tx;
        end
        idx = 9;
        rp[k] = 1'b0;
        if (pe) begin
            wait_until(s + 9 * d + d / 2);
            rp[k] = tx;
            idx = 10;
        end
        wait_until(s + idx * d + d / 2);
        chk("stop_bit", {31'b0, tx}, 32'd1);
        if (s2) begin
            wait_until(s + (idx + 1) * d + d / 2);
            chk("stop_bit2", {31'b0, tx}, 32'd1);
        end
        rs[k] = s;
        rb[k] = b;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int busy_hi;
        int acc2;

        // Reset values
        #3 rst_n = 1'b0;
        #1;
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_ready", {31'b0, wready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_bytes", bsent, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, wready}, 32'd1);

        // div=10, 8N1, one word
        cfg_div = 16'd10; par_en = 1'b0; stop2 = 1'b0;
        push(32'h00200113, n_acc);
        for (int k = 0; k < 4; k++) rx(10, 1'b0, 1'b0, k);
        chk("latency", rs[0] - n_acc, 32'd2);
        chk("b33_byte0", {24'b0, rb[0]}, 32'h13);
        chk("b33_byte1", {24'b0, rb[1]}, 32'h01);
        chk("b33_byte2", {24'b0, rb[2]}, 32'h20);
        chk("b33_byte3", {24'b0, rb[3]}, 32'h00);
        for (int k = 1; k < 4; k++) chk("b33_frame_len", rs[k] - rs[k-1], 32'd100);
        wait_until(rs[3] + 99);
        chk("b33_busy_in_stop", {31'b0, busy}, 32'd1);
        chk("b33_count_in_stop", bsent, 32'd3);
        wait_until(rs[3] + 100);
        chk("b33_busy_end", {31'b0, busy}, 32'd0);
        chk("b33_count_end", bsent, 32'd4);

        // div=4 parity even then odd
        apply_reset();
        cfg_div = 16'd4; par_en = 1'b1; par_odd = 1'b0;
        push(32'h00000013, n_acc);
        for (int k = 0; k < 4; k++) rx(4, 1'b1, 1'b0, k);
        chk("even_byte", {24'b0, rb[0]}, 32'h13);
        chk("even_par_13", {31'b0, rp[0]}, 32'd1);
        chk("even_par_00", {31'b0, rp[1]}, 32'd0);
        chk("par_frame_len", rs[1] - rs[0], 32'd44);
        par_odd = 1'b1;
        push(32'h00000013, n_acc);
        for (int k = 4; k < 8; k++) rx(4, 1'b1, 1'b0, k);
        chk("odd_byte", {24'b0, rb[4]}, 32'h13);
        chk("odd_par_13", {31'b0, rp[4]}, 32'd0);
        chk("odd_par_00", {31'b0, rp[5]}, 32'd1);
        chk("odd_frame_len", rs[5] - rs[4], 32'd44);

        // Two stop bits, div=8, two words back-to-back
        apply_reset();
        cfg_div = 16'd8; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b1;
        push(32'h44332211, n_acc);
        push(32'h88776655, acc2);
        for (int k = 0; k < 8; k++) rx(8, 1'b0, 1'b1, k);
        for (int k = 0; k < 8; k++) chk("stop2_byte", {24'b0, rb[k]}, 32'h11 * (k + 1));
        for (int k = 1; k < 8; k++) chk("stop2_frame_len", rs[k] - rs[k-1], 32'd88);

        // FIFO back-pressure, six words, div=16
        apply_reset();
        cfg_div = 16'd16; stop2 = 1'b0;
        words[0] = 32'h03020100; words[1] = 32'h07060504; words[2] = 32'h0B0A0908;
        words[3] = 32'h0F0E0D0C; words[4] = 32'h13121110; words[5] = 32'h17161514;
        fork
            begin
                for (int w = 0; w < 5; w++) push(words[w], n_acc);
                @(negedge clk);
                chk("ready_full", {31'b0, wready}, 32'd0);
                push(words[5], acc2);
            end
            begin
                for (int k = 0; k < 24; k++) begin
                    rx(16, 1'b0, 1'b0, k);
                    chk("fifo_byte", {24'b0, rb[k]}, 32'(k));
                end
            end
        join
        for (int k = 1; k < 24; k++) chk("fifo_frame_len", rs[k] - rs[k-1], 32'd160);
        wait_until(rs[23] + 159);
        chk("fifo_busy_last_stop", {31'b0, busy}, 32'd1);
        wait_until(rs[23] + 160);
        chk("fifo_busy_fall", {31'b0, busy}, 32'd0);
        chk("fifo_count", bsent, 32'd24);

        // Reset during data bit 3 of the second byte
        apply_reset();
        cfg_div = 16'd10;
        push(32'h1234F00F, n_acc);
        push(32'h00000077, acc2);
        rx(10, 1'b0, 1'b0, 0);
        chk("abort_byte0", {24'b0, rb[0]}, 32'h0F);
        wait_start(rs[1]);
        wait_until(rs[1] + 45);
        chk("abort_pre_bit3", {31'b0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", {31'b0, tx}, 32'd1);
        chk("abort_ready", {31'b0, wready}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_count", bsent, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_before_edge", {31'b0, wready}, 32'd0);
        @(negedge clk);
        chk("abort_ready_after_edge", {31'b0, wready}, 32'd1);
        lows = 0;
        busy_hi = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busy_hi++;
        end
        chk("abort_line_idle", lows, 32'd0);
        chk("abort_busy_idle", busy_hi, 32'd0);
        chk("abort_count_idle", bsent, 32'd0);

        // div=0 and div=1 both mean two cycles per bit
        cfg_div = 16'd0;
        push(32'h5AC3A55A, n_acc);
        for (int k = 0; k < 4; k++) rx(0, 1'b0, 1'b0, k);
        chk("div0_latency", rs[0] - n_acc, 32'd2);
        chk("div0_byte0", {24'b0, rb[0]}, 32'h5A);
        chk("div0_byte1", {24'b0, rb[1]}, 32'hA5);
        chk("div0_byte2", {24'b0, rb[2]}, 32'hC3);
        chk("div0_byte3", {24'b0, rb[3]}, 32'h5A);
        for (int k = 1; k < 4; k++) chk("div0_frame_len", rs[k] - rs[k-1], 32'd20);
        wait_until(rs[3] + 20);
        chk("div0_count", bsent, 32'd4);
        chk("div0_busy", {31'b0, busy}, 32'd0);
        cfg_div = 16'd1;
        push(32'h00000081, n_acc);
        for (int k = 4; k < 6; k++) rx(1, 1'b0, 1'b0, k);
        chk("div1_byte", {24'b0, rb[4]}, 32'h81);
        chk("div1_frame_len", rs[5] - rs[4], 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
